// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage valid bits, register enables, load-use
// bubble, EX redirect squash, data-memory freeze and saturating event counters.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifu_valid,
  input  logic [4:0]       idu_rs1,
  input  logic [4:0]       idu_rs2,
  input  logic             idu_use_rs1,
  input  logic             idu_use_rs2,
  input  logic [4:0]       exu_rd,
  input  logic             exu_r_wen,
  input  logic             exu_mem_ren,
  input  logic             exu_redirect,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             idu_valid,
  output logic             exu_valid,
  output logic             mem_valid,
  output logic             wbu_valid,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             pc_sel,
  output logic             stalled,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_redirect,
  output logic [CNT_W-1:0] cnt_mem_wait
);

  typedef enum logic {RUN, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  // vld bit order: [0]=ID, [1]=EX, [2]=MEM, [3]=WB
  logic [3:0]       vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       event_inc;    // [0]=load-use, [1]=redirect, [2]=mem wait

  logic hold;
  logic hazard;
  logic redirect_go;
  logic load_use_go;

  always_comb begin
    hazard = vld_q[1] & exu_mem_ren & exu_r_wen & (exu_rd != 5'd0) & vld_q[0] &
             ((idu_use_rs1 & (idu_rs1 == exu_rd)) | (idu_use_rs2 & (idu_rs2 == exu_rd)));
    // In WAIT the MEM contents are held, so only mem_ready decides release.
    hold        = (state_q == WAIT) ? ~mem_ready : (vld_q[2] & mem_access & ~mem_ready);
    redirect_go = ~hold & vld_q[1] & exu_redirect;
    load_use_go = ~hold & ~redirect_go & hazard;
  end

  always_comb begin
    state_d   = state_q;
    vld_d     = vld_q;
    event_inc = 3'b000;
    pc_en     = 1'b0;
    if_id_en  = 1'b0;
    id_ex_en  = 1'b0;
    ex_mem_en = 1'b0;
    mem_wb_en = 1'b0;
    pc_sel    = 1'b0;

    if (hold) begin
      state_d      = WAIT;
      event_inc[2] = 1'b1;
    end else begin
      state_d   = RUN;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      vld_d[3]  = vld_q[2];
      vld_d[2]  = vld_q[1];
      if (redirect_go) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        pc_sel       = 1'b1;
        vld_d[1]     = 1'b0;
        vld_d[0]     = 1'b0;
        event_inc[1] = 1'b1;
      end else if (load_use_go) begin
        vld_d[1]     = 1'b0;
        vld_d[0]     = vld_q[0];
        event_inc[0] = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        vld_d[1] = vld_q[0];
        vld_d[0] = ifu_valid;
      end
    end

    if (!rst_n) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      pc_sel    = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (event_inc[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      vld_q   <= 4'b0000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign idu_valid    = vld_q[0];
  assign exu_valid    = vld_q[1];
  assign mem_valid    = vld_q[2];
  assign wbu_valid    = vld_q[3];
  assign stalled      = (state_q == WAIT);
  assign cnt_load_use = cnt_q[0];
  assign cnt_redirect = cnt_q[1];
  assign cnt_mem_wait = cnt_q[2];

endmodule
